// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - shared VGA 640x480 timing constants, capture state and pixel types
package vga_pkg;

    // 640x480 @ 60 Hz mode, also used by the timing generator
    localparam int unsigned H_ACTIVE = 640;
    localparam int unsigned H_FRONT  = 16;
    localparam int unsigned H_SYNC   = 96;
    localparam int unsigned H_BACK   = 48;
    localparam int unsigned H_TOTAL  = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
    localparam int unsigned V_ACTIVE = 480;
    localparam int unsigned V_FRONT  = 10;
    localparam int unsigned V_SYNC   = 2;
    localparam int unsigned V_BACK   = 33;
    localparam int unsigned V_TOTAL  = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

    localparam int unsigned CNT_W = 10;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MEASURE = 2'd1,
        CAPTURE = 2'd2
    } cap_state_t;

    typedef logic [23:0] rgb_t;

    // Saturating increment for the 10-bit position counters
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/vga_edge_det.sv
// rtl/vga_edge_det.sv - falling-edge detector for already-registered hsync/vsync
// Ports:
//   i_clk, i_rst_n        pixel clock, async active-low reset
//   i_hsync, i_vsync      registered sync inputs (active low)
//   o_hs_fall, o_vs_fall  one-cycle pulse when the sync input goes 1 -> 0
module vga_edge_det (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_hsync,
    input  logic i_vsync,
    output logic o_hs_fall,
    output logic o_vs_fall
);

    logic r_hs_prev;
    logic r_vs_prev;

    // Previous values reset low so a sync held low through reset is not
    // mistaken for an edge once reset releases.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_hs_prev <= 1'b0;
            r_vs_prev <= 1'b0;
        end else begin
            r_hs_prev <= i_hsync;
            r_vs_prev <= i_vsync;
        end
    end

    assign o_hs_fall = r_hs_prev & ~i_hsync;
    assign o_vs_fall = r_vs_prev & ~i_vsync;

endmodule

// File: rtl/vga_capture.sv
// rtl/vga_capture.sv - VGA receive side: geometry lock and active-pixel capture into a FIFO
// Ports:
//   i_clk, i_rst_n                 pixel clock, async active-low reset
//   i_hsync, i_vsync, i_blank_n    VGA timing (syncs active low, blank_n high = active)
//   i_red, i_green, i_blue         pixel colour
//   i_fifo_full, i_ovf_clr         downstream back-pressure, sticky overflow clear
//   o_fifo_wreq, o_fifo_wdata      write strobe and {r,g,b}
//   o_pix_x, o_pix_y               coordinates of the written pixel
//   o_frame_start                  pulse with the write of pixel (0,0)
//   o_locked, o_overflow           geometry verified, sticky dropped-pixel flag
module vga_capture
    import vga_pkg::*;
#(
    parameter int unsigned P_H_ACTIVE = H_ACTIVE,
    parameter int unsigned P_V_ACTIVE = V_ACTIVE
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_hsync,
    input  logic             i_vsync,
    input  logic             i_blank_n,
    input  logic [7:0]       i_red,
    input  logic [7:0]       i_green,
    input  logic [7:0]       i_blue,
    input  logic             i_fifo_full,
    input  logic             i_ovf_clr,
    output logic             o_fifo_wreq,
    output logic [23:0]      o_fifo_wdata,
    output logic [CNT_W-1:0] o_pix_x,
    output logic [CNT_W-1:0] o_pix_y,
    output logic             o_frame_start,
    output logic             o_locked,
    output logic             o_overflow
);

    localparam logic [CNT_W-1:0] LP_H = CNT_W'(P_H_ACTIVE);
    localparam logic [CNT_W-1:0] LP_V = CNT_W'(P_V_ACTIVE);

    logic             r_s_hsync;
    logic             r_s_vsync;
    logic             r_s_blank_n;
    rgb_t             r_s_rgb;
    logic             w_hs_fall;
    logic             w_vs_fall;
    logic [CNT_W-1:0] r_x_cnt;
    logic [CNT_W-1:0] r_y_cnt;
    logic             r_geom_err;
    logic             w_line_bad;
    logic [CNT_W-1:0] w_y_eff;
    logic             w_frame_ok;
    cap_state_t       r_state;
    cap_state_t       w_state_nxt;
    logic             w_wr;
    logic             w_drop;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_s_hsync   <= 1'b0;
            r_s_vsync   <= 1'b0;
            r_s_blank_n <= 1'b0;
            r_s_rgb     <= '0;
        end else begin
            r_s_hsync   <= i_hsync;
            r_s_vsync   <= i_vsync;
            r_s_blank_n <= i_blank_n;
            r_s_rgb     <= {i_red, i_green, i_blue};
        end
    end

    vga_edge_det u_edge_det (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .i_hsync   (r_s_hsync),
        .i_vsync   (r_s_vsync),
        .o_hs_fall (w_hs_fall),
        .o_vs_fall (w_vs_fall)
    );

    // The line still held in x_cnt is folded into the frame check, so a VS
    // edge coinciding with the HS edge that ends the last line still counts it.
    assign w_line_bad = (r_x_cnt != '0) && (r_x_cnt != LP_H);
    assign w_y_eff    = (r_x_cnt != '0) ? sat_inc(r_y_cnt) : r_y_cnt;
    assign w_frame_ok = (w_y_eff == LP_V) && !r_geom_err && !w_line_bad;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_x_cnt    <= '0;
            r_y_cnt    <= '0;
            r_geom_err <= 1'b0;
        end else if (w_vs_fall) begin
            r_x_cnt    <= '0;
            r_y_cnt    <= '0;
            r_geom_err <= 1'b0;
        end else if (w_hs_fall) begin
            r_x_cnt <= '0;
            if (r_x_cnt != '0) begin
                r_y_cnt <= sat_inc(r_y_cnt);
            end
            if (w_line_bad) begin
                r_geom_err <= 1'b1;
            end
        end else if (r_s_blank_n) begin
            r_x_cnt <= sat_inc(r_x_cnt);
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Write decision uses the state before any VS transition in this cycle.
    always_comb begin
        w_state_nxt = r_state;
        w_wr        = 1'b0;
        w_drop      = 1'b0;
        if (r_state == CAPTURE && r_s_blank_n) begin
            w_wr   = !i_fifo_full;
            w_drop = i_fifo_full;
        end
        if (w_vs_fall) begin
            case (r_state)
                IDLE:    w_state_nxt = MEASURE;
                MEASURE: w_state_nxt = w_frame_ok ? CAPTURE : MEASURE;
                CAPTURE: w_state_nxt = w_frame_ok ? CAPTURE : MEASURE;
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_fifo_wreq   <= 1'b0;
            o_fifo_wdata  <= '0;
            o_pix_x       <= '0;
            o_pix_y       <= '0;
            o_frame_start <= 1'b0;
            o_overflow    <= 1'b0;
        end else begin
            o_fifo_wreq   <= w_wr;
            o_frame_start <= w_wr && (r_x_cnt == '0) && (r_y_cnt == '0);
            if (w_wr) begin
                o_fifo_wdata <= r_s_rgb;
                o_pix_x      <= r_x_cnt;
                o_pix_y      <= r_y_cnt;
            end
            // A drop in the same cycle as a clear keeps the flag set
            if (w_drop) begin
                o_overflow <= 1'b1;
            end else if (i_ovf_clr) begin
                o_overflow <= 1'b0;
            end
        end
    end

    assign o_locked = (r_state == CAPTURE);

endmodule

// File: doc/vga_capture.md
# vga_capture

Receive-side counterpart of the VGA timing generator. Samples a VGA-style pixel stream (hsync, vsync, blank_n, 24-bit RGB) synchronous to the local pixel clock. Verifies frame geometry against the 640x480 mode and, once locked, writes each active pixel with its coordinates into a downstream FIFO. It sits between a loopback or external VGA source and the frame-store FIFO.

## Interface
- H_ACTIVE, 640, active pixels per line
- V_ACTIVE, 480, active lines per frame
- clk  in  1  pixel clock; all inputs synchronous to it
- rst_n  in  1  asynchronous, active-low reset
- hsync  in  1  horizontal sync, active low
- vsync  in  1  vertical sync, active low
- blank_n  in  1  high = active video
- red, green, blue  in  8 each  pixel colour
- fifo_full  in  1  downstream FIFO cannot accept a write
- ovf_clr  in  1  clears sticky overflow
- fifo_wreq  out  1  write strobe
- fifo_wdata  out  24  {red, green, blue} of written pixel
- pix_x  out  10  column of the pixel on fifo_wdata
- pix_y  out  10  row of the pixel on fifo_wdata
- frame_start  out  1  one-cycle pulse coincident with the write of pixel (0,0)
- locked  out  1  geometry verified; capture enabled
- overflow  out  1  sticky: an active pixel was dropped due to fifo_full

## Operation
- Input stage: all VGA inputs are registered once (s_*). A second register holds the previous hsync and vsync values for edge detection.
- VS edge: s_vsync = 0 and previous s_vsync = 1. HS edge is defined the same way on hsync.
- x_cnt (10b): increments on each active sample (s_blank_n = 1), saturates at 1023, and clears on HS edge.
- y_cnt (10b): increments on HS edge when the ending line had x_cnt > 0, saturates at 1023, and clears on VS edge.
- geom_err: set on HS edge if the ending line had x_cnt ∉ {0, H_ACTIVE}. Cleared on VS edge after evaluation.
- FSM, reset state IDLE:
  - IDLE: go to MEASURE on VS edge.
  - MEASURE: on VS edge, go to CAPTURE if y_cnt = V_ACTIVE and !geom_err. Otherwise stay in MEASURE with counters restarted.
  - CAPTURE: on VS edge with mismatch, go to MEASURE and deassert locked. The mismatching frame's pixels have already been written.
- locked = (state == CAPTURE).
- Write rule: in CAPTURE, an active sample with fifo_full = 0 produces fifo_wreq = 1, carrying its data and its pre-increment x_cnt and y_cnt.
- Active sample in CAPTURE with fifo_full = 1:
  - no write; the pixel is dropped
  - overflow sets
  - x_cnt still increments
- overflow: cleared by ovf_clr. If set and clear conditions occur in the same cycle, set wins.
- Simultaneous HS and VS edge: VS processing takes priority. Both counters clear, and the ending line is included in the frame check before clearing.
- Reset (any time, including mid-frame): state IDLE, all counters 0, all outputs 0.

## Timing
- Reset values: fifo_wreq 0, fifo_wdata 0, pix_x 0, pix_y 0, frame_start 0, locked 0, overflow 0.
- Latency: a pixel on the inputs at edge N appears on fifo_wreq/fifo_wdata after edge N+2. This is one input register plus one output register.
- fifo_full is sampled in the same cycle as the registered active sample, not the raw input.
- locked rises two cycles after the VS edge appears on the inputs, and falls on the same relative cycle.
- fifo_wreq is never asserted for two pixels in the same cycle and never outside CAPTURE.
- frame_start is asserted only together with fifo_wreq at pix_x = 0, pix_y = 0. If that pixel is dropped, there is no frame_start for that frame.

## Structure
- Shared package vga_pkg holds:
  - H_ACTIVE, V_ACTIVE, and the porch and sync constants also used by the generator
  - typedef cap_state_t {IDLE, MEASURE, CAPTURE}
  - typedef rgb_t (24b packed)
- One natural sub-module, vga_edge_det: registers hsync and vsync and emits the hs_fall and vs_fall pulses. It is reused by any future sync monitor.
- Counters, FSM and write logic live in vga_capture.

## Test plan
- Reset mid-frame: drive a conforming frame, then pulse rst_n low at pixel (100, 50) → all outputs 0 immediately. Two further conforming frames → locked = 1 at the second VS edge.
- Lock and capture: feed the timing generator output looped back with a pixel ramp (data = x + 1024·y) → locked after frame 1. Frame 2 produces exactly 307200 writes, with pix_x/pix_y matching data and one frame_start.
- Short line: frame with line 10 carrying 639 active pixels → stays in MEASURE (locked = 0). The next conforming frame locks.
- Loss of lock: while locked, send a frame with 479 active lines → locked drops two cycles after the following VS edge. The frame after that relocks.
- Overflow: hold fifo_full = 1 for pixels (5..7, 20) → 3 pixels missing, overflow = 1, and pix_x resumes at 8. Pulse ovf_clr → overflow = 0. With ovf_clr and a drop in the same cycle → overflow stays 1.
- Coincident edges: assert HS and VS falling in the same cycle at frame end → y_cnt is checked as 480, lock is retained, and the next frame starts at (0,0).
